// File: rtl/bf16_acc_dispatch.sv
// Dispatches BF16 core requests to an accelerator and returns results with a timeout guard.
// Optional macro BF16_DISPATCH_STICKY_EN adds a sticky exception-flag register on fflags.
module bf16_acc_dispatch #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [15:0] req_b,
   input  logic [31:0] req_c,
   input  logic [4:0]  req_rd,
   output logic        acc_enable,
   output logic [3:0]  acc_operation,
   output logic [31:0] acc_operand_a,
   output logic [15:0] acc_operand_b,
   output logic [31:0] acc_operand_c,
   input  logic [31:0] acc_result,
   input  logic [3:0]  acc_fpcsr,
   input  logic        acc_valid,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic [3:0]  rsp_fpcsr,
   output logic [4:0]  rsp_rd,
   output logic        rsp_err,
   input  logic        fflags_clr,
   output logic [3:0]  fflags
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] OP_MAX    = 4'b1010;
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t      state_r;
   logic [7:0]  wait_cnt_r;
   logic [4:0]  rd_r;
   logic        req_ready_r;
   logic        acc_enable_r;
   logic [3:0]  acc_operation_r;
   logic [31:0] acc_operand_a_r;
   logic [15:0] acc_operand_b_r;
   logic [31:0] acc_operand_c_r;
   logic        rsp_valid_r;
   logic [31:0] rsp_result_r;
   logic [3:0]  rsp_fpcsr_r;
   logic [4:0]  rsp_rd_r;
   logic        rsp_err_r;
   logic        rsp_handshake_s;

   function automatic logic op_legal(input logic [3:0] op);
      return (op <= OP_MAX);
   endfunction

   assign rsp_handshake_s = rsp_valid_r && rsp_ready;

   // Dispatch FSM; every output is a register that is zero outside the state that owns it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r         <= IDLE;
         wait_cnt_r      <= 8'd0;
         rd_r            <= 5'd0;
         req_ready_r     <= 1'b1;
         acc_enable_r    <= 1'b0;
         acc_operation_r <= 4'd0;
         acc_operand_a_r <= 32'd0;
         acc_operand_b_r <= 16'd0;
         acc_operand_c_r <= 32'd0;
         rsp_valid_r     <= 1'b0;
         rsp_result_r    <= 32'd0;
         rsp_fpcsr_r     <= 4'd0;
         rsp_rd_r        <= 5'd0;
         rsp_err_r       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_valid) begin
                  req_ready_r <= 1'b0;
                  if (op_legal(req_op)) begin
                     state_r         <= BUSY;
                     wait_cnt_r      <= 8'd0;
                     rd_r            <= req_rd;
                     acc_enable_r    <= 1'b1;
                     acc_operation_r <= req_op;
                     acc_operand_a_r <= req_a;
                     acc_operand_b_r <= req_b;
                     acc_operand_c_r <= req_c;
                  end else begin
                     // Illegal opcode: answer with an error without touching the accelerator
                     state_r      <= RESP;
                     rsp_valid_r  <= 1'b1;
                     rsp_result_r <= 32'd0;
                     rsp_fpcsr_r  <= 4'd0;
                     rsp_rd_r     <= req_rd;
                     rsp_err_r    <= 1'b1;
                  end
               end else begin
                  req_ready_r <= 1'b1;
               end
            end
            BUSY: begin
               if (acc_valid || (wait_cnt_r == WAIT_LAST)) begin
                  // acc_valid wins over a coincident timeout
                  state_r         <= RESP;
                  wait_cnt_r      <= 8'd0;
                  acc_enable_r    <= 1'b0;
                  acc_operation_r <= 4'd0;
                  acc_operand_a_r <= 32'd0;
                  acc_operand_b_r <= 16'd0;
                  acc_operand_c_r <= 32'd0;
                  rsp_valid_r     <= 1'b1;
                  rsp_rd_r        <= rd_r;
                  rd_r            <= 5'd0;
                  rsp_result_r    <= acc_valid ? acc_result : 32'd0;
                  rsp_fpcsr_r     <= acc_valid ? acc_fpcsr : 4'd0;
                  rsp_err_r       <= ~acc_valid;
               end else begin
                  wait_cnt_r <= wait_cnt_r + 8'd1;
               end
            end
            RESP: begin
               if (rsp_handshake_s) begin
                  state_r      <= IDLE;
                  req_ready_r  <= 1'b1;
                  rsp_valid_r  <= 1'b0;
                  rsp_result_r <= 32'd0;
                  rsp_fpcsr_r  <= 4'd0;
                  rsp_rd_r     <= 5'd0;
                  rsp_err_r    <= 1'b0;
               end else begin
                  rsp_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r      <= IDLE;
               req_ready_r  <= 1'b1;
               acc_enable_r <= 1'b0;
               rsp_valid_r  <= 1'b0;
            end
         endcase
      end
   end

`ifdef BF16_DISPATCH_STICKY_EN
   logic [3:0] fflags_r;

   // Sticky flags: accumulate on each handshake; a coincident clear keeps only the new flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fflags_r <= 4'd0;
      end else if (fflags_clr) begin
         fflags_r <= rsp_handshake_s ? rsp_fpcsr_r : 4'd0;
      end else if (rsp_handshake_s) begin
         fflags_r <= fflags_r | rsp_fpcsr_r;
      end else begin
         fflags_r <= fflags_r;
      end
   end

   assign fflags = fflags_r;
`else
   logic sticky_unused_s;

   assign sticky_unused_s = fflags_clr;
   assign fflags          = 4'd0;
`endif

   assign req_ready     = req_ready_r;
   assign acc_enable    = acc_enable_r;
   assign acc_operation = acc_operation_r;
   assign acc_operand_a = acc_operand_a_r;
   assign acc_operand_b = acc_operand_b_r;
   assign acc_operand_c = acc_operand_c_r;
   assign rsp_valid     = rsp_valid_r;
   assign rsp_result    = rsp_result_r;
   assign rsp_fpcsr     = rsp_fpcsr_r;
   assign rsp_rd        = rsp_rd_r;
   assign rsp_err       = rsp_err_r;

endmodule

// File: tb/tb_bf16_acc_dispatch.sv
// Self-checking bench for bf16_acc_dispatch: directed cases plus randomized transactions vs. a transaction-level model.
module tb_bf16_acc_dispatch;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_a, req_c;
   logic [15:0] req_b;
   logic [4:0]  req_rd;
   logic        acc_enable;
   logic [3:0]  acc_operation;
   logic [31:0] acc_operand_a, acc_operand_c;
   logic [15:0] acc_operand_b;
   logic [31:0] acc_result;
   logic [3:0]  acc_fpcsr;
   logic        acc_valid;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_fpcsr;
   logic [4:0]  rsp_rd;
   logic        rsp_err;
   logic        fflags_clr;
   logic [3:0]  fflags;

   int          checks = 0;
   int          errors = 0;
   logic [3:0]  fflags_m;

   bf16_acc_dispatch #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_rd(req_rd),
      .acc_enable(acc_enable), .acc_operation(acc_operation),
      .acc_operand_a(acc_operand_a), .acc_operand_b(acc_operand_b), .acc_operand_c(acc_operand_c),
      .acc_result(acc_result), .acc_fpcsr(acc_fpcsr), .acc_valid(acc_valid),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_fpcsr(rsp_fpcsr), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
      .fflags_clr(fflags_clr), .fflags(fflags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sticky-flag model: what fflags should read after a handshake carrying fp.
   function automatic logic [3:0] flags_after(input logic [3:0] cur, input logic [3:0] fp, input logic clr);
`ifdef BF16_DISPATCH_STICKY_EN
      return clr ? fp : (cur | fp);
`else
      return 4'd0;
`endif
   endfunction

   // One transaction. d = index of the enable cycle in which the accelerator raises acc_valid.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [15:0] b,
                         input logic [31:0] c, input logic [4:0] rd, input int d,
                         input logic [31:0] res, input logic [3:0] fp, input int bp, input logic clr);
      int exp_en, exp_lat, en_cnt, lat;
      logic [31:0] exp_res;
      logic [3:0]  exp_fp;
      logic        exp_err;
      logic        done;
      if (op > 4'd10) begin
         exp_en = 0; exp_lat = 1; exp_res = 32'd0; exp_fp = 4'd0; exp_err = 1'b1;
      end else if (d < TO) begin
         exp_en = d + 1; exp_lat = d + 2; exp_res = res; exp_fp = fp; exp_err = 1'b0;
      end else begin
         exp_en = TO; exp_lat = TO + 1; exp_res = 32'd0; exp_fp = 4'd0; exp_err = 1'b1;
      end
      chk("req_ready_idle", req_ready, 32'd1);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_c = c; req_rd = rd;
      acc_valid = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0; req_op = 4'($urandom); req_a = $urandom; req_rd = 5'($urandom);
      en_cnt = 0; lat = 1; done = 1'b0;
      while (!done && lat < 400) begin
         if (rsp_valid) begin
            done = 1'b1;
         end else begin
            if (acc_enable) begin
               chk("acc_operation", acc_operation, op);
               chk("acc_operand_a", acc_operand_a, a);
               chk("acc_operand_b", acc_operand_b, b);
               chk("acc_operand_c", acc_operand_c, c);
               acc_valid  = (en_cnt == d);
               acc_result = (en_cnt == d) ? res : $urandom;
               acc_fpcsr  = (en_cnt == d) ? fp : 4'($urandom);
               en_cnt++;
            end else begin
               acc_valid = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
         end
      end
      chk("rsp_seen", done, 32'd1);
      chk("latency", lat, exp_lat);
      chk("enable_cycles", en_cnt, exp_en);
      chk("rsp_result", rsp_result, exp_res);
      chk("rsp_fpcsr", rsp_fpcsr, exp_fp);
      chk("rsp_rd", rsp_rd, rd);
      chk("rsp_err", rsp_err, exp_err);
      chk("acc_enable_resp", acc_enable, 32'd0);
      chk("acc_operand_a_resp", acc_operand_a, 32'd0);
      chk("req_ready_resp", req_ready, 32'd0);
      // Stray accelerator traffic outside BUSY must be ignored.
      acc_valid = 1'b1; acc_result = $urandom; acc_fpcsr = 4'($urandom);
      repeat (bp) begin
         rsp_ready = 1'b0;
         @(posedge clk); #1;
         chk("bp_rsp_valid", rsp_valid, 32'd1);
         chk("bp_rsp_result", rsp_result, exp_res);
         chk("bp_rsp_fpcsr", rsp_fpcsr, exp_fp);
         chk("bp_rsp_rd", rsp_rd, rd);
         chk("bp_rsp_err", rsp_err, exp_err);
         chk("bp_req_ready", req_ready, 32'd0);
      end
      rsp_ready = 1'b1; fflags_clr = clr;
      @(posedge clk); #1;
      rsp_ready = 1'b0; fflags_clr = 1'b0;
      fflags_m = flags_after(fflags_m, exp_fp, clr);
      chk("post_rsp_valid", rsp_valid, 32'd0);
      chk("post_req_ready", req_ready, 32'd1);
      chk("post_rsp_result", rsp_result, 32'd0);
      chk("post_rsp_rd", rsp_rd, 32'd0);
      chk("post_rsp_err", rsp_err, 32'd0);
      chk("post_acc_enable", acc_enable, 32'd0);
      chk("fflags", fflags, fflags_m);
      acc_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_a = 32'd0; req_b = 16'd0;
      req_c = 32'd0; req_rd = 5'd0; acc_result = 32'd0; acc_fpcsr = 4'd0; acc_valid = 1'b0;
      rsp_ready = 1'b0; fflags_clr = 1'b0; fflags_m = 4'd0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("rst_req_ready", req_ready, 32'd1);
      chk("rst_acc_enable", acc_enable, 32'd0);
      chk("rst_acc_operand_a", acc_operand_a, 32'd0);
      chk("rst_rsp_valid", rsp_valid, 32'd0);
      chk("rst_rsp_result", rsp_result, 32'd0);
      chk("rst_fflags", fflags, 32'd0);
      @(posedge clk); #1;

      // Basic op with a registered accelerator (3-cycle request-to-response).
      run_op(4'b0100, 32'h3F80_0000, 16'h3F80, 32'd0, 5'd5, 1, 32'h4000_0000, 4'd0, 0, 1'b0);
      // Illegal opcodes, including the first one above the legal range.
      run_op(4'b1111, 32'h1234_5678, 16'hABCD, 32'h1, 5'd3, 0, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
      run_op(4'b1011, 32'h5, 16'h6, 32'h7, 5'd9, 0, 32'h1, 4'h1, 1, 1'b0);
      // Highest legal opcode with a combinational accelerator.
      run_op(4'b1010, 32'hCAFE_0001, 16'h1111, 32'h2222_3333, 5'd31, 0, 32'h0BAD_F00D, 4'h8, 0, 1'b0);
      // Timeout, and acc_valid coinciding with the last wait cycle.
      run_op(4'b0001, 32'h1, 16'h2, 32'h3, 5'd7, 99, 32'h5555_5555, 4'h3, 0, 1'b0);
      run_op(4'b0010, 32'h9, 16'h8, 32'h7, 5'd12, TO - 1, 32'h7777_1234, 4'h2, 0, 1'b0);
      // Long backpressure.
      run_op(4'b0011, 32'hAAAA_5555, 16'h5A5A, 32'h0F0F_F0F0, 5'd17, 2, 32'h3C3C_C3C3, 4'h4, 5, 1'b0);

      // Sticky flags: clear while idle, accumulate two ops, then clear coincident with a handshake.
      fflags_clr = 1'b1;
      @(posedge clk); #1;
      fflags_clr = 1'b0; fflags_m = 4'd0;
      chk("fflags_idle_clr", fflags, 32'd0);
      run_op(4'b0101, 32'h1, 16'h1, 32'h1, 5'd1, 1, 32'h10, 4'b0001, 0, 1'b0);
      run_op(4'b0110, 32'h2, 16'h2, 32'h2, 5'd2, 1, 32'h20, 4'b0100, 0, 1'b0);
`ifdef BF16_DISPATCH_STICKY_EN
      chk("fflags_accum", fflags, 32'b0101);
`endif
      run_op(4'b0111, 32'h3, 16'h3, 32'h3, 5'd4, 1, 32'h30, 4'b0010, 1, 1'b1);
`ifdef BF16_DISPATCH_STICKY_EN
      chk("fflags_clr_hs", fflags, 32'b0010);
`endif

      // Randomized transactions.
      for (int i = 0; i < 25; i++) begin
         run_op(4'($urandom_range(0, 15)), $urandom, 16'($urandom), $urandom, 5'($urandom),
                int'($urandom_range(0, TO + 3)), $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 3) == 0));
      end

      // Reset two cycles after acceptance abandons the operation.
      chk("rb_req_ready", req_ready, 32'd1);
      req_valid = 1'b1; req_op = 4'b0010; req_a = 32'h1357_9BDF; req_b = 16'h2468; req_c = 32'h1; req_rd = 5'd6;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rb_busy_enable", acc_enable, 32'd1);
      reset = 1'b1;
      #1;
      chk("rb_async_enable", acc_enable, 32'd0);
      chk("rb_async_operand_a", acc_operand_a, 32'd0);
      chk("rb_async_rsp_valid", rsp_valid, 32'd0);
      fflags_m = 4'd0;
      acc_valid = 1'b1; acc_result = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         chk("rb_no_rsp", rsp_valid, 32'd0);
         chk("rb_req_ready", req_ready, 32'd1);
         chk("rb_acc_enable", acc_enable, 32'd0);
      end
      chk("rb_fflags", fflags, 32'd0);
      acc_valid = 1'b0;
      run_op(4'b1000, 32'h0102_0304, 16'h0506, 32'h0708_090A, 5'd21, 3, 32'h4242_4242, 4'h1, 2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bf16_acc_dispatch.md
BF16_ACC_DISPATCH -- requirements
Module: bf16_acc_dispatch

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: cycles acc_enable stays high without acc_valid before the operation is abandoned; range 2..255.
REQ-002 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req_valid in 1, req_ready out 1, req_op in 4, req_a in 32, req_b in 16, req_c in 32, req_rd in 5: core request channel with destination register tag.
REQ-005 SHALL have ports acc_enable out 1, acc_operation out 4, acc_operand_a out 32, acc_operand_b out 16, acc_operand_c out 32: drive to accelerator.
REQ-006 SHALL have ports acc_result in 32, acc_fpcsr in 4, acc_valid in 1: accelerator return.
REQ-007 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_result out 32, rsp_fpcsr out 4, rsp_rd out 5, rsp_err out 1: writeback channel.
REQ-008 SHALL have ports fflags_clr in 1, fflags out 4: sticky exception flags.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY, RESP; reset state IDLE.
REQ-010 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready.
REQ-011 On acceptance with req_op <= 4'b1010, SHALL register op, operands and rd and go to BUSY next cycle.
REQ-012 On acceptance with req_op > 4'b1010, SHALL go directly to RESP with rsp_result=0, rsp_fpcsr=0, rsp_err=1; accelerator not enabled.
REQ-013 In BUSY, acc_enable SHALL be 1 and acc_operation/acc_operand_* SHALL hold the registered values; outside BUSY acc_enable=0 and acc_* data=0.
REQ-014 In BUSY, acc_valid=1 SHALL capture acc_result, acc_fpcsr into response registers, set rsp_err=0, and move to RESP next cycle.
REQ-015 An 8-bit wait counter SHALL clear on entry to BUSY and increment each BUSY cycle; when it reaches TIMEOUT-1 without acc_valid, SHALL move to RESP with rsp_result=0, rsp_fpcsr=0, rsp_err=1.
REQ-016 acc_valid and timeout in the same cycle SHALL resolve as acc_valid (result captured, rsp_err=0).
REQ-017 acc_valid outside BUSY SHALL be ignored.
REQ-018 In RESP, rsp_valid SHALL be 1 and rsp_* SHALL be stable until rsp_ready=1; on handshake, SHALL return to IDLE (no same-cycle new acceptance; req_ready rises the following cycle).
REQ-019 Outside RESP, rsp_valid=0 and rsp_result/rsp_fpcsr/rsp_rd/rsp_err SHALL read 0.
REQ-020 Latency: request accepted at edge N, acc_enable high from N+1, acc_valid seen at edge M yields rsp_valid from M+1; minimum request-to-response 3 cycles with a registered accelerator.

Reset
REQ-021 reset SHALL asynchronously force IDLE, counter 0, all registered operands/results 0, fflags 0.
REQ-022 Reset outputs SHALL be: req_ready=1 after release, acc_enable=0, rsp_valid=0, all data outputs 0.
REQ-023 Reset during BUSY or RESP SHALL abandon the operation; no response is produced after release.

Configuration
REQ-024 Macro BF16_DISPATCH_STICKY_EN SHALL compile in the sticky flag register.
REQ-025 With BF16_DISPATCH_STICKY_EN defined: on each rsp handshake fflags |= rsp_fpcsr; fflags_clr=1 clears fflags; clear and handshake in the same cycle yield fflags = rsp_fpcsr.
REQ-026 Without BF16_DISPATCH_STICKY_EN: fflags SHALL be constant 0 and fflags_clr ignored; all other behaviour unchanged.

Verification
REQ-027 Add: req_op=4'b0100, req_a=32'h3F80_0000, req_b=16'h3F80, rd=5; accelerator returns acc_valid one cycle after enable with result 32'h4000_0000, fpcsr 0 -> rsp_valid 3 cycles after acceptance, rsp_result=32'h4000_0000, rsp_rd=5, rsp_err=0.
REQ-028 Illegal: req_op=4'b1111, rd=3 -> rsp_valid the cycle after acceptance, rsp_result=0, rsp_err=1, acc_enable never 1.
REQ-029 Timeout: TIMEOUT=16, acc_valid held 0 -> acc_enable high exactly 16 cycles, then rsp_valid with rsp_err=1, rsp_result=0.
REQ-030 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0 throughout; rsp_ready=1 -> req_ready=1 next cycle.
REQ-031 Reset mid-BUSY: assert reset 2 cycles after acceptance -> acc_enable=0 immediately (asynchronous), no rsp_valid after release, req_ready=1.
REQ-032 Sticky (macro on): two ops with fpcsr 4'b0001 then 4'b0100 -> fflags=4'b0101; fflags_clr coincident with a handshake of fpcsr 4'b0010 -> fflags=4'b0010.
